instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Boot-time writer for the instruction memory. Receives a length-prefixed byte stream
//  (valid/ready) and packs it little-endian into 32-bit words. Writes the words to the
//  instruction RAM write port from FIRST_INSTR_ADDR upward.
//  Holds the core in reset (cpu_rst_o) until the image is fully written.
// PARAMETERS
//  ADDR_EXP          12             log2 of memory capacity in bytes (4096)
//  BYTE_SIZE         8              stream byte width
//  DATA_WIDTH        32             word / address width
//  FIRST_INSTR_ADDR  32'hBFC00000   first byte address written
//  LAST_INSTR_ADDR   32'hBFC00FFF   last valid byte address; CAP_BYTES = LAST-FIRST+1
// PORTS
//  clk_i         in   1    single clock, all logic rising-edge
//  rst_i         in   1    synchronous, active-high reset
//  start_i       in   1    pulse: begin new load (honoured in IDLE, DONE, ERROR only)
//  byte_valid_i  in   1    stream byte present
//  byte_data_i   in   8    stream byte
//  byte_ready_o  out  1    loader accepts byte; handshake = valid & ready
//  wr_en_o       out  1    one-cycle write strobe to instruction RAM
//  wr_addr_o     out  32   word-aligned byte address of write
//  wr_data_o     out  32   word, byte lane k = k-th byte of the group
//  busy_o        out  1    high in HDR/DATA
//  done_o        out  1    image loaded
//  error_o       out  1    header length exceeds CAP_BYTES
//  cpu_rst_o     out  1    core reset; low only in DONE
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except cpu_rst_o=1. Counters, len, word cleared.
//  - All outputs registered. Bytes are consumed only on a handshake.
//  - IDLE: byte_ready_o=0. start_i -> HDR. done_o and error_o are cleared on entry to HDR.
//  - HDR: byte_ready_o=1. Four bytes accepted little-endian into len[31:0].
//    After the 4th byte:
//      len==0            -> DONE
//      len>CAP_BYTES     -> ERROR (unsigned 32-bit compare)
//      otherwise         -> DATA
//    wr_addr base = FIRST_INSTR_ADDR.
//  - DATA: byte_ready_o=1. Each accepted byte lands in lane cnt[1:0]; cnt counts bytes.
//    A group completes on the lane-3 byte, or on the byte where cnt+1==len.
//    On completion:
//      wr_en_o=1 the following cycle, with wr_data_o = packed word.
//      Unfilled upper lanes of a final partial word are 8'h00.
//      wr_addr advances by 4 after each write.
//    byte_ready_o stays high, so a byte may be accepted in the same cycle as the write
//    pulse (back-to-back, no bubbles). After the final write -> DONE.
//  - DONE: done_o=1, cpu_rst_o=0, byte_ready_o=0; start_i -> HDR (cpu_rst_o=1 again).
//  - ERROR: error_o=1, cpu_rst_o=1, no writes; start_i -> HDR.
//  - start_i in HDR/DATA is ignored. byte_valid_i in IDLE/DONE/ERROR is not consumed.
//  - rst_i mid-load: aborts. No further wr_en_o. Next cycle all outputs are at reset
//    values. RAM keeps the partial image, but the core stays in reset.
//  - Address never passes LAST_INSTR_ADDR-3 because of the len check.
//    Highest write address is FIRST+CAP_BYTES-4.
//  - Write latency: 1 cycle from the completing byte handshake to wr_en_o.
// STRUCTURE
//  - instr_mem_pkg holds:
//      loader_state_t enum {IDLE,HDR,DATA,DONE,ERROR}
//      FIRST_INSTR_ADDR, LAST_INSTR_ADDR, CAP_BYTES localparams
//    The package is shared with instruction_memory so both agree on the address map.
//  - One sub-module, byte_packer: lane counter plus 32-bit little-endian assembly
//    register, with flush-on-last input and zero fill. The FSM, len, cnt and address
//    counter live in the top.
// TESTING
//  1. rst_i; start_i; stream 08 00 00 00 13 00 50 00 93 00 10 00 ->
//     writes (BFC00000, 00500013) then (BFC00004, 00100093); done_o=1, cpu_rst_o=0.
//  2. len=5 (05 00 00 00), data AA BB CC DD EE ->
//     (BFC00000, DDCCBBAA) then (BFC00004, 000000EE); exactly 2 writes.
//  3. len=0 -> DONE the cycle after the 4th header byte; no wr_en_o; cpu_rst_o=0.
//  4. len=0x00001001 -> error_o=1, busy_o=0, no writes, cpu_rst_o=1;
//     then start_i plus a valid image -> done_o=1, error_o=0.
//  5. Case 1 with byte_valid_i every 3rd cycle -> identical writes.
//     Separately, rst_i after 6 data bytes -> exactly one write, all outputs at
//     reset values next cycle.
//  6. len=4096, continuous stream -> 1024 writes, last at BFC00FFC.
//     start_i pulsed mid-DATA has no effect. start_i in DONE reloads from BFC00000.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Address map and loader types shared by the instruction-memory loader and the
// instruction memory itself.
package instr_mem_pkg;

  localparam int ADDR_EXP   = 12;
  localparam int BYTE_SIZE  = 8;
  localparam int DATA_WIDTH = 32;
  localparam int LANES      = DATA_WIDTH / BYTE_SIZE;
  localparam int LANE_W     = $clog2(LANES);

  localparam logic [DATA_WIDTH-1:0] FIRST_INSTR_ADDR = 32'hBFC00000;
  localparam logic [DATA_WIDTH-1:0] LAST_INSTR_ADDR  = FIRST_INSTR_ADDR + (32'd1 << ADDR_EXP) - 32'd1;
  localparam logic [DATA_WIDTH-1:0] CAP_BYTES        = LAST_INSTR_ADDR - FIRST_INSTR_ADDR + 32'd1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Control, byte-stream and RAM write-port bundle of the instruction memory loader.
interface instr_mem_loader_if;
  import instr_mem_pkg::*;

  logic                  start_i;
  logic                  byte_valid_i;
  logic [BYTE_SIZE-1:0]  byte_data_i;
  logic                  byte_ready_o;
  logic                  wr_en_o;
  logic [DATA_WIDTH-1:0] wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  logic                  cpu_rst_o;

  modport slave (
    input  start_i, byte_valid_i, byte_data_i,
    output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
    output busy_o, done_o, error_o, cpu_rst_o
  );

  modport master (
    output start_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
    input  busy_o, done_o, error_o, cpu_rst_o
  );

endinterface

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: fills lanes 0..3 and emits a registered word
// on the lane-3 byte or on an early last byte, with unfilled upper lanes left at zero.
module byte_packer
  import instr_mem_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic [BYTE_SIZE-1:0]  data_i,
  input  logic                  last_i,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  word_valid_q, word_valid_d;
  logic [DATA_WIDTH-1:0] merged;
  logic                  flush;

  // The accumulator is zeroed after every flush, so a short final group is zero-filled.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign merged[gi*BYTE_SIZE +: BYTE_SIZE] =
      (lane_q == LANE_W'(gi)) ? data_i : acc_q[gi*BYTE_SIZE +: BYTE_SIZE];
  end

  assign flush = valid_i && ((lane_q == LANE_W'(LANES - 1)) || last_i);

  always_comb begin
    lane_d       = lane_q;
    acc_d        = acc_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear_i) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (flush) begin
      word_d       = merged;
      word_valid_d = 1'b1;
      acc_d        = '0;
      lane_d       = '0;
    end else if (valid_i) begin
      acc_d  = merged;
      lane_d = lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q       <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: takes a 4-byte little-endian length header plus image bytes and writes
// them as 32-bit words into instruction RAM, holding the core in reset until complete.
module instr_mem_loader
  import instr_mem_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  instr_mem_loader_if.slave  bus
);

  loader_state_t         state_q, state_d;
  logic [1:0]            hdr_cnt_q, hdr_cnt_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_rst_q, cpu_rst_d;

  logic                  hs;
  logic                  pk_clear, pk_valid, pk_last;
  logic                  pk_word_valid;
  logic [DATA_WIDTH-1:0] pk_word;

  assign hs = bus.byte_valid_i && byte_ready_q;

  byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (pk_clear),
    .valid_i      (pk_valid),
    .data_i       (bus.byte_data_i),
    .last_i       (pk_last),
    .word_valid_o (pk_word_valid),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    pk_clear  = 1'b0;
    pk_valid  = 1'b0;
    pk_last   = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (bus.start_i) begin
          state_d   = HDR;
          hdr_cnt_d = '0;
          len_d     = '0;
          cnt_d     = '0;
          addr_d    = FIRST_INSTR_ADDR;
          pk_clear  = 1'b1;
        end
      end
      HDR: begin
        if (hs) begin
          len_d[hdr_cnt_q*BYTE_SIZE +: BYTE_SIZE] = bus.byte_data_i;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if (len_d == '0)            state_d = DONE;
            else if (len_d > CAP_BYTES) state_d = ERROR;
            else                        state_d = DATA;
          end
        end
      end
      DATA: begin
        if (hs) begin
          pk_valid = 1'b1;
          pk_last  = (cnt_q + 32'd1 == len_q);
          cnt_d    = cnt_q + 32'd1;
        end
        // The write of the final word is the last thing that happens in DATA.
        if (pk_word_valid) begin
          addr_d = addr_q + 32'd4;
          if (cnt_q == len_q) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready drops as soon as the last image byte is taken so nothing extra is consumed
    // while the final word is being written.
    byte_ready_d = (state_d == HDR) || ((state_d == DATA) && (cnt_d != len_d));
    busy_d       = (state_d == HDR) || (state_d == DATA);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERROR);
    cpu_rst_d    = (state_d != DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      hdr_cnt_q    <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_rst_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_rst_q    <= cpu_rst_d;
    end
  end

  assign bus.byte_ready_o = byte_ready_q;
  assign bus.wr_en_o      = pk_word_valid;
  assign bus.wr_addr_o    = addr_q;
  assign bus.wr_data_o    = pk_word;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.error_o      = error_q;
  assign bus.cpu_rst_o    = cpu_rst_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: header/image streams with hand-computed writes.
module tb_instr_mem_loader;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  instr_mem_loader_if bus ();

  instr_mem_loader dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;
  int tmo_cnt = 0;
  int gap     = 0;
  int base;

  // Write log, filled on the rising edge with the values the RAM would capture.
  logic [31:0] log_addr [2048];
  logic [31:0] log_data [2048];
  int          wr_n = 0;

  always @(posedge clk_i) begin
    if (bus.wr_en_o && wr_n < 2048) begin
      log_addr[wr_n] = bus.wr_addr_o;
      log_data[wr_n] = bus.wr_data_o;
      wr_n = wr_n + 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  function automatic logic [5:0] flags();
    return {bus.byte_ready_o, bus.wr_en_o, bus.busy_o, bus.done_o, bus.error_o, bus.cpu_rst_o};
  endfunction

  task automatic pulse_start();
    bus.start_i = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    while (!bus.byte_ready_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= 50) tmo_cnt++;
    @(negedge clk_i);
    bus.byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic wait_end(input string tag);
    int k;
    k = 0;
    while (!(bus.done_o || bus.error_o) && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk(tag, 32'(k < 50), 32'd1);
  endtask

  logic [7:0] img1 [$];
  logic [7:0] img2 [$];

  initial begin
    img1 = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
    img2 = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    bus.start_i      = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("reset_flags", 32'(flags()), 32'b000001);
    chk("reset_addr", bus.wr_addr_o, 32'h0);
    chk("reset_data", bus.wr_data_o, 32'h0);
    rst_i = 1'b0;
    bus.byte_valid_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("idle_no_ready", 32'(flags()), 32'b000001);
    bus.byte_valid_i = 1'b0;

    // 1: two full words
    base = wr_n;
    pulse_start();
    chk("t1_hdr_flags", 32'(flags()), 32'b101001);
    send_bytes(img1);
    wait_end("t1_end");
    chk("t1_nwr", 32'(wr_n - base), 32'd2);
    chk("t1_a0", log_addr[base], 32'hBFC00000);
    chk("t1_d0", log_data[base], 32'h00500013);
    chk("t1_a1", log_addr[base+1], 32'hBFC00004);
    chk("t1_d1", log_data[base+1], 32'h00100093);
    chk("t1_done_flags", 32'(flags()), 32'b000100);

    // 2: partial final word
    base = wr_n;
    pulse_start();
    send_bytes(img2);
    wait_end("t2_end");
    repeat (3) @(negedge clk_i);
    chk("t2_nwr", 32'(wr_n - base), 32'd2);
    chk("t2_a0", log_addr[base], 32'hBFC00000);
    chk("t2_d0", log_data[base], 32'hDDCCBBAA);
    chk("t2_a1", log_addr[base+1], 32'hBFC00004);
    chk("t2_d1", log_data[base+1], 32'h000000EE);

    // 3: zero length goes straight to DONE
    base = wr_n;
    pulse_start();
    send_bytes('{8'h00, 8'h00, 8'h00, 8'h00});
    chk("t3_done_now", 32'(flags()), 32'b000100);
    repeat (3) @(negedge clk_i);
    chk("t3_nwr", 32'(wr_n - base), 32'd0);

    // 4: oversize header, then recovery
    base = wr_n;
    pulse_start();
    send_bytes('{8'h01, 8'h10, 8'h00, 8'h00});
    wait_end("t4_end");
    chk("t4_err_flags", 32'(flags()), 32'b000011);
    repeat (3) @(negedge clk_i);
    chk("t4_nwr", 32'(wr_n - base), 32'd0);
    pulse_start();
    chk("t4_err_cleared", 32'(flags()), 32'b101001);
    send_bytes(img1);
    wait_end("t4_reload_end");
    chk("t4_reload_flags", 32'(flags()), 32'b000100);
    chk("t4_reload_nwr", 32'(wr_n - base), 32'd2);

    // 5: sparse stream gives identical writes
    base = wr_n;
    gap = 2;
    pulse_start();
    send_bytes(img1);
    gap = 0;
    wait_end("t5_end");
    chk("t5_nwr", 32'(wr_n - base), 32'd2);
    chk("t5_a0", log_addr[base], 32'hBFC00000);
    chk("t5_d0", log_data[base], 32'h00500013);
    chk("t5_a1", log_addr[base+1], 32'hBFC00004);
    chk("t5_d1", log_data[base+1], 32'h00100093);

    // 5b: reset after 6 data bytes of an 8-byte image
    base = wr_n;
    pulse_start();
    send_bytes('{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t5_rst_flags", 32'(flags()), 32'b000001);
    chk("t5_rst_addr", bus.wr_addr_o, 32'h0);
    chk("t5_rst_data", bus.wr_data_o, 32'h0);
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("t5_rst_nwr", 32'(wr_n - base), 32'd1);
    chk("t5_rst_d0", log_data[base], 32'h44332211);

    // 6: full-capacity image with a stray start mid-stream
    base = wr_n;
    pulse_start();
    send_bytes('{8'h00, 8'h10, 8'h00, 8'h00});
    for (int i = 0; i < 4096; i++) begin
      bus.start_i = (i == 100);
      send_byte(i[7:0]);
    end
    bus.start_i = 1'b0;
    wait_end("t6_end");
    chk("t6_nwr", 32'(wr_n - base), 32'd1024);
    chk("t6_mid_addr", log_addr[base+25], 32'hBFC00064);
    chk("t6_mid_data", log_data[base+25], 32'h67666564);
    chk("t6_last_addr", log_addr[base+1023], 32'hBFC00FFC);
    chk("t6_last_data", log_data[base+1023], 32'hFFFEFDFC);
    chk("t6_done_flags", 32'(flags()), 32'b000100);

    base = wr_n;
    pulse_start();
    chk("t6_restart_rst", 32'(bus.cpu_rst_o), 32'd1);
    send_bytes(img1);
    wait_end("t6_reload_end");
    chk("t6_reload_a0", log_addr[base], 32'hBFC00000);
    chk("t6_reload_d0", log_data[base], 32'h00500013);

    chk("ready_timeouts", 32'(tmo_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
